// File: rtl/stack_queue_pkg.sv
// Shared constants and width helpers for the stack/queue buffer.
`default_nettype none
package stack_queue_pkg;

  localparam logic MODE_LIFO = 1'b0;
  localparam logic MODE_FIFO = 1'b1;

  // Index width into the array; clamped so a 1-entry array still gets a bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sqb_mem_2p.sv
// Register array: one synchronous write port, one asynchronous read port.
`default_nettype none
module sqb_mem_2p #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/stack_queue_buf.sv
// Run-time selectable LIFO/FIFO buffer with registered read port, occupancy
// count, almost-full threshold and sticky overflow/underflow flags.
`default_nettype none
module stack_queue_buf
  import stack_queue_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_err_i,
  input  logic [WIDTH-1:0]           data_in_i,
  output logic [WIDTH-1:0]           data_out_o,
  output logic                       rd_valid_o,
  output logic [cnt_w(DEPTH)-1:0]    count_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       almost_full_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
  output logic                       mode_active_o
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             mode_active_q, mode_d;
  logic [WIDTH-1:0] data_out_q;
  logic             rd_valid_q;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             pop_acc, push_acc;
  logic [PTR_W-1:0] rd_idx, wr_idx;
  logic [PTR_W-1:0] cnt_ptr, top_ptr;
  logic [WIDTH-1:0] rdata;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mode_d   = (count_q == '0) ? mode_i : mode_active_q;
    pop_acc  = pop_i && (count_q != '0);
    // A full buffer still takes a push when a pop frees a slot the same cycle.
    push_acc = push_i && ((count_q != CNT_W'(DEPTH)) || pop_acc);
    count_d  = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);

    cnt_ptr  = PTR_W'(count_q);
    top_ptr  = cnt_ptr - PTR_W'(1);

    rd_idx   = rd_ptr_q;
    wr_idx   = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (mode_d == MODE_LIFO) begin
      rd_idx   = top_ptr;
      wr_idx   = pop_acc ? top_ptr : cnt_ptr;
      rd_ptr_d = '0;
      wr_ptr_d = PTR_W'(count_d);
    end else begin
      if (pop_acc)  rd_ptr_d = wrap_inc(rd_ptr_q);
      if (push_acc) wr_ptr_d = wrap_inc(wr_ptr_q);
    end

    overflow_d  = (push_i && !push_acc) || (overflow_q && !clear_err_i);
    underflow_d = (pop_i && !pop_acc)   || (underflow_q && !clear_err_i);
  end

  sqb_mem_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_acc),
    .waddr_i (wr_idx),
    .wdata_i (data_in_i),
    .raddr_i (rd_idx),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      mode_active_q <= MODE_LIFO;
      data_out_q    <= '0;
      rd_valid_q    <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      mode_active_q <= mode_d;
      rd_valid_q    <= pop_acc;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      if (pop_acc) data_out_q <= rdata;
    end
  end

  assign data_out_o    = data_out_q;
  assign rd_valid_o    = rd_valid_q;
  assign count_o       = count_q;
  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == CNT_W'(DEPTH));
  assign almost_full_o = (count_q >= CNT_W'(AF_LEVEL));
  assign overflow_o    = overflow_q;
  assign underflow_o   = underflow_q;
  assign mode_active_o = mode_active_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_queue_buf.sv
// Directed self-checking bench for stack_queue_buf (WIDTH=8, DEPTH=4).
`default_nettype none
module tb_stack_queue_buf;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_i = 1'b0;
  logic       push_i = 1'b0;
  logic       pop_i = 1'b0;
  logic       clear_err_i = 1'b0;
  logic [7:0] data_in_i = 8'h00;
  logic [7:0] data_out_o;
  logic       rd_valid_o;
  logic [2:0] count_o;
  logic       empty_o, full_o, almost_full_o;
  logic       overflow_o, underflow_o, mode_active_o;

  int checks = 0;
  int errors = 0;

  stack_queue_buf #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mode_i        (mode_i),
    .push_i        (push_i),
    .pop_i         (pop_i),
    .clear_err_i   (clear_err_i),
    .data_in_i     (data_in_i),
    .data_out_o    (data_out_o),
    .rd_valid_o    (rd_valid_o),
    .count_o       (count_o),
    .empty_o       (empty_o),
    .full_o        (full_o),
    .almost_full_o (almost_full_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o),
    .mode_active_o (mode_active_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // One clock cycle of stimulus; returns 1 time unit after the edge.
  task automatic cyc(input logic p, input logic q, input logic [7:0] d, input logic ce);
    push_i = p; pop_i = q; data_in_i = d; clear_err_i = ce;
    @(posedge clk); #1;
    push_i = 1'b0; pop_i = 1'b0; clear_err_i = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
    checks++; if ({empty_o, full_o, almost_full_o} !== 3'b100) begin errors++; $display("FAIL reset_flags got %b exp 100", {empty_o, full_o, almost_full_o}); end
    checks++; if ({rd_valid_o, overflow_o, underflow_o, mode_active_o} !== 4'b0000) begin errors++; $display("FAIL reset_status got %b exp 0000", {rd_valid_o, overflow_o, underflow_o, mode_active_o}); end
    checks++; if (data_out_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data_out_o); end
    rst = 1'b0;
  endtask

  task automatic test_lifo;
    mode_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 8'h0A + 8'(i), 1'b0);
      checks++; if (count_o !== 3'(i + 1)) begin errors++; $display("FAIL lifo_push_count got %0d exp %0d", count_o, i + 1); end
    end
    checks++; if ({full_o, almost_full_o, overflow_o} !== 3'b110) begin errors++; $display("FAIL lifo_full got %b exp 110", {full_o, almost_full_o, overflow_o}); end
    cyc(1'b1, 1'b0, 8'h0E, 1'b0);
    checks++; if ({count_o, full_o, overflow_o} !== {3'd4, 2'b11}) begin errors++; $display("FAIL lifo_overflow got %0d/%b/%b exp 4/1/1", count_o, full_o, overflow_o); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL lifo_clear got %b exp 0", overflow_o); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      checks++; if ({rd_valid_o, data_out_o} !== {1'b1, 8'h0D - 8'(i)}) begin errors++; $display("FAIL lifo_pop got v=%b d=%h exp v=1 d=%h", rd_valid_o, data_out_o, 8'h0D - 8'(i)); end
      checks++; if (count_o !== 3'(3 - i)) begin errors++; $display("FAIL lifo_pop_count got %0d exp %0d", count_o, 3 - i); end
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL lifo_empty got %b exp 1", empty_o); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if ({rd_valid_o, data_out_o} !== {1'b0, 8'h0A}) begin errors++; $display("FAIL lifo_hold got v=%b d=%h exp v=0 d=0a", rd_valid_o, data_out_o); end
  endtask

  task automatic test_fifo_wrap;
    logic [7:0] exp_q [4];
    exp_q = '{8'h03, 8'h04, 8'h05, 8'h06};
    mode_i = 1'b1;
    cyc(1'b1, 1'b0, 8'h01, 1'b0);
    checks++; if (mode_active_o !== 1'b1) begin errors++; $display("FAIL fifo_mode got %b exp 1", mode_active_o); end
    cyc(1'b1, 1'b0, 8'h02, 1'b0);
    cyc(1'b1, 1'b0, 8'h03, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (data_out_o !== 8'h01) begin errors++; $display("FAIL fifo_pop1 got %h exp 01", data_out_o); end
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (data_out_o !== 8'h02) begin errors++; $display("FAIL fifo_pop2 got %h exp 02", data_out_o); end
    for (int i = 4; i <= 6; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0);
    checks++; if ({count_o, full_o} !== {3'd4, 1'b1}) begin errors++; $display("FAIL fifo_wrap_full got %0d/%b exp 4/1", count_o, full_o); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      checks++; if ({rd_valid_o, data_out_o} !== {1'b1, exp_q[i]}) begin errors++; $display("FAIL fifo_drain got v=%b d=%h exp v=1 d=%h", rd_valid_o, data_out_o, exp_q[i]); end
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL fifo_empty got %b exp 1", empty_o); end
  endtask

  task automatic test_simul_lifo;
    mode_i = 1'b0;
    cyc(1'b1, 1'b0, 8'h01, 1'b0);
    checks++; if (mode_active_o !== 1'b0) begin errors++; $display("FAIL sl_mode got %b exp 0", mode_active_o); end
    cyc(1'b1, 1'b0, 8'h02, 1'b0);
    cyc(1'b1, 1'b1, 8'h09, 1'b0);
    checks++; if ({count_o, rd_valid_o, data_out_o} !== {3'd2, 1'b1, 8'h02}) begin errors++; $display("FAIL sl_both got c=%0d v=%b d=%h exp c=2 v=1 d=02", count_o, rd_valid_o, data_out_o); end
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (data_out_o !== 8'h09) begin errors++; $display("FAIL sl_pop9 got %h exp 09", data_out_o); end
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if ({data_out_o, empty_o} !== {8'h01, 1'b1}) begin errors++; $display("FAIL sl_pop1 got d=%h e=%b exp d=01 e=1", data_out_o, empty_o); end
  endtask

  task automatic test_simul_full_fifo;
    mode_i = 1'b1;
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0);
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL sf_full got %b exp 1", full_o); end
    cyc(1'b1, 1'b1, 8'h05, 1'b0);
    checks++; if ({count_o, data_out_o, overflow_o} !== {3'd4, 8'h01, 1'b0}) begin errors++; $display("FAIL sf_both got c=%0d d=%h o=%b exp c=4 d=01 o=0", count_o, data_out_o, overflow_o); end
    for (int i = 2; i <= 5; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      checks++; if (data_out_o !== 8'(i)) begin errors++; $display("FAIL sf_drain got %h exp %h", data_out_o, 8'(i)); end
    end
  endtask

  task automatic test_errors;
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if ({underflow_o, rd_valid_o, data_out_o} !== {2'b10, 8'h05}) begin errors++; $display("FAIL err_underflow got u=%b v=%b d=%h exp u=1 v=0 d=05", underflow_o, rd_valid_o, data_out_o); end
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    checks++; if (underflow_o !== 1'b1) begin errors++; $display("FAIL err_clear_race got %b exp 1", underflow_o); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", underflow_o); end
    cyc(1'b1, 1'b1, 8'h3C, 1'b0);
    checks++; if ({count_o, underflow_o, rd_valid_o} !== {3'd1, 2'b10}) begin errors++; $display("FAIL err_push_empty_pop got c=%0d u=%b v=%b exp c=1 u=1 v=0", count_o, underflow_o, rd_valid_o); end
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    checks++; if ({data_out_o, underflow_o} !== {8'h3C, 1'b0}) begin errors++; $display("FAIL err_nobypass got d=%h u=%b exp d=3c u=0", data_out_o, underflow_o); end
  endtask

  task automatic test_mode;
    mode_i = 1'b0;
    cyc(1'b1, 1'b0, 8'h11, 1'b0);
    cyc(1'b1, 1'b0, 8'h22, 1'b0);
    mode_i = 1'b1;
    cyc(1'b1, 1'b0, 8'h33, 1'b0);
    checks++; if (mode_active_o !== 1'b0) begin errors++; $display("FAIL mode_ignored got %b exp 0", mode_active_o); end
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if ({mode_active_o, data_out_o} !== {1'b0, 8'h33}) begin errors++; $display("FAIL mode_lifo_pop got m=%b d=%h exp m=0 d=33", mode_active_o, data_out_o); end
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if ({data_out_o, empty_o} !== {8'h11, 1'b1}) begin errors++; $display("FAIL mode_drain got d=%h e=%b exp d=11 e=1", data_out_o, empty_o); end
    cyc(1'b1, 1'b0, 8'h07, 1'b0);
    checks++; if (mode_active_o !== 1'b1) begin errors++; $display("FAIL mode_switch got %b exp 1", mode_active_o); end
    cyc(1'b1, 1'b0, 8'h08, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (data_out_o !== 8'h07) begin errors++; $display("FAIL mode_fifo_order got %h exp 07", data_out_o); end
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (data_out_o !== 8'h08) begin errors++; $display("FAIL mode_fifo_order2 got %h exp 08", data_out_o); end
  endtask

  task automatic test_reset_mid;
    mode_i = 1'b1;
    cyc(1'b1, 1'b0, 8'h55, 1'b0);
    cyc(1'b1, 1'b0, 8'h66, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++; if ({count_o, empty_o, full_o, almost_full_o} !== {3'd0, 3'b100}) begin errors++; $display("FAIL rstmid_count got c=%0d flags=%b exp c=0 flags=100", count_o, {empty_o, full_o, almost_full_o}); end
    checks++; if ({rd_valid_o, mode_active_o, overflow_o, underflow_o, data_out_o} !== {4'b0000, 8'h00}) begin errors++; $display("FAIL rstmid_status got %b d=%h exp 0000 d=00", {rd_valid_o, mode_active_o, overflow_o, underflow_o}, data_out_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1'b1, 1'b0, 8'hAB, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if ({rd_valid_o, data_out_o} !== {1'b1, 8'hAB}) begin errors++; $display("FAIL rstmid_index0 got v=%b d=%h exp v=1 d=ab", rd_valid_o, data_out_o); end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_fifo_wrap();
    test_simul_lifo();
    test_simul_full_fifo();
    test_errors();
    test_mode();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stack_queue_buf.md
# stack_queue_buf

Parametrised storage buffer, successor to the team's single-mode stack controller: one register array serving as a LIFO stack or a FIFO queue, with the mode selected at run time while the buffer is empty. It adds accepted simultaneous push/pop, a registered read port with valid strobe, an occupancy count, an almost-full threshold, and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain, for example as an operand stack or a command queue.

## Interface
- WIDTH, 32, data width in bits (≥1)
- DEPTH, 16, number of entries (≥2; power of two not required)
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  requested mode (0 = LIFO, 1 = FIFO); honoured only while empty
- push  in  1  write request
- pop  in  1  read request
- clear_err  in  1  clears overflow/underflow
- data_in  in  WIDTH  write data
- data_out  out  WIDTH  registered read data
- rd_valid  out  1  data_out updated by a pop accepted in the previous cycle
- count  out  $clog2(DEPTH+1)  occupancy
- empty, full, almost_full  out  1 each  derived from registered count
- overflow, underflow  out  1 each  sticky error flags
- mode_active  out  1  mode currently in force

## Operation
- Reset (asynchronous): count=0, rd_ptr=wr_ptr=0, mode_active=0, data_out=0, rd_valid=0, overflow=underflow=0, empty=1, full=almost_full=0. Array contents are not reset.
- Effective mode for a cycle: `mode` if count==0 at cycle start, otherwise mode_active. mode_active loads the effective mode every cycle.
- LIFO: write index = count; read index = count-1. Each LIFO cycle loads rd_ptr←0 and wr_ptr←next count.
- FIFO: write index = wr_ptr; read index = rd_ptr. Each pointer advances by 1 on its own accepted operation and wraps explicitly from DEPTH-1 to 0.
- Acceptance: a pop is accepted iff count>0. A push is accepted iff count<DEPTH or a pop is accepted in the same cycle.
- Push+pop both accepted, LIFO: data_out takes the old top; data_in overwrites the same entry (count-1); count is unchanged.
- Push+pop both accepted, FIFO: the read uses the pre-edge array contents; the write lands at wr_ptr; both pointers advance; count is unchanged. This includes the full case, where wr_ptr==rd_ptr.
- Push when empty with a simultaneous pop: the push is accepted, the pop is rejected, and underflow is set. There is no bypass.
- Rejected push (full, no pop): data is dropped, overflow←1. Rejected pop (empty): underflow←1, rd_valid←0, data_out is held.
- clear_err clears both flags. A new error in the same cycle wins, so the flag stays 1.
- data_out holds its value until the next accepted pop.

## Timing
- Pop latency: 1 cycle. An accepted pop at edge N updates data_out at edge N, and rd_valid is high for exactly the cycle after edge N.
- count, empty, full and almost_full update at the same edge as the operation. There is no combinational path from push or pop to any output.
- Mode change takes effect on the first cycle whose starting count==0. A mode request while non-empty is ignored until the buffer drains.
- Reset asserted mid-operation aborts immediately; the first accepted push after reset writes index 0.

## Structure
- Package stack_queue_pkg: MODE_LIFO=1'b0 and MODE_FIFO=1'b1 constants; pointer width PTR_W=$clog2(DEPTH); count width CNT_W=$clog2(DEPTH+1).
- Sub-module sqb_mem_2p: DEPTH×WIDTH register array with one synchronous write port and one asynchronous read port. The controller registers the read data into data_out.
- Controller: pointer/count update, acceptance logic, flags, mode latch.

## Test plan
- LIFO, DEPTH=4: push 0xA,0xB,0xC,0xD; a 5th push 0xE → full=1, overflow=1, count=4. Then pop ×4 → data_out 0xD,0xC,0xB,0xA, each with a rd_valid pulse; empty=1.
- FIFO wrap, DEPTH=4: push 1,2,3, pop 2, push 4,5,6 → count=4, full. Pop ×4 → 3,4,5,6.
- Simultaneous, LIFO holding {0x1,0x2}: push 0x9 + pop → data_out=0x2, count=2. Next pop → 0x9.
- Simultaneous at full, FIFO holding 1..4: push 5 + pop → data_out=1, count=4. Drain → 2,3,4,5.
- Empty: pop → underflow=1, rd_valid=0. clear_err with a simultaneous pop → underflow stays 1. clear_err alone → 0.
- Mode: set mode=1 while holding 2 entries → mode_active stays 0. Drain, then push 0x7 with mode=1 → mode_active=1 and FIFO ordering. Assert rst mid-stream → all outputs at reset values.
